// File: rtl/dmem_pkg.sv
// Shared types and helpers for the latency-configurable data memory.
//   state_t      : request FSM states
//   LATENCY_MAX  : largest supported access latency
//   merge_bytes  : byte-lane merge of new data over an old word (up to 64 bits)
//   addr_ok      : aligned and in-range check of a byte address
package dmem_pkg;

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

  localparam int unsigned LATENCY_MAX = 8;

  // Lanes with be set take new_w, the rest keep old_w.
  function automatic logic [63:0] merge_bytes(input logic [63:0] old_w,
                                              input logic [63:0] new_w,
                                              input logic [7:0]  be);
    logic [63:0] res;
    res = old_w;
    for (int b = 0; b < 8; b++) begin
      if (be[b]) res[8*b +: 8] = new_w[8*b +: 8];
    end
    return res;
  endfunction

  // True when the low off_bits are zero and the word index is below depth.
  function automatic logic addr_ok(input logic [31:0]  addr,
                                   input int unsigned  off_bits,
                                   input int unsigned  depth);
    logic [31:0] mask;
    mask = (32'd1 << off_bits) - 32'd1;
    return ((addr & mask) == 32'd0) && ((addr >> off_bits) < depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH register array with byte-lane write enables.
//   clk_i, rst_i : clock, synchronous active-high clear of every word
//   we_i, be_i   : write strobe and byte-lane enables
//   addr_i       : word index shared by read and write
//   wdata_i      : write data
//   rdata_o      : combinational read of the addressed word (pre-write value)
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 64,
  parameter int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               we_i,
  input  logic [WIDTH/8-1:0] be_i,
  input  logic [AddrW-1:0]   addr_i,
  input  logic [WIDTH-1:0]   wdata_i,
  output logic [WIDTH-1:0]   rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [63:0]      merged;

  always_comb begin
    merged = merge_bytes(64'(mem_q[addr_i]), 64'(wdata_i), 8'(be_i));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[addr_i] <= merged[WIDTH-1:0];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_lat.sv
// Data memory with configurable access latency and a valid/ready request port.
//   clk_i, rst_i     : clock, synchronous active-high reset (clears memory too)
//   req_valid_i      : request present; req_ready_o: request can be accepted now
//   req_we_i         : 1 = write, 0 = read
//   req_be_i         : byte-lane write enables (ignored on reads)
//   req_addr_i       : byte address; req_wdata_i: write data
//   rsp_valid_o      : one-cycle response strobe, LATENCY cycles after acceptance
//   rsp_rdata_o      : read data (0 for writes and errors); rsp_err_o: rejected request
module dmem_lat
  import dmem_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned DEPTH   = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               req_valid_i,
  output logic               req_ready_o,
  input  logic               req_we_i,
  input  logic [WIDTH/8-1:0] req_be_i,
  input  logic [31:0]        req_addr_i,
  input  logic [WIDTH-1:0]   req_wdata_i,
  output logic               rsp_valid_o,
  output logic [WIDTH-1:0]   rsp_rdata_o,
  output logic               rsp_err_o
);

  localparam int unsigned OffBits = $clog2(WIDTH / 8);
  localparam int unsigned AddrW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW    = $clog2(LATENCY_MAX + 1);

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  pend_rdata_q, pend_rdata_d;
  logic              pend_err_q, pend_err_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic              accept;
  logic              req_ok;
  logic [31:0]       word_addr;
  logic [AddrW-1:0]  word_idx;
  logic [WIDTH-1:0]  arr_rdata;
  logic [WIDTH-1:0]  fresh_rdata;
  logic              unused_addr_bits;

  assign word_addr        = req_addr_i >> OffBits;
  assign word_idx         = word_addr[AddrW-1:0];
  assign unused_addr_bits = ^word_addr[31:AddrW];
  assign req_ok           = addr_ok(req_addr_i, OffBits, DEPTH);

  // Ready follows the state; gating with rst_i keeps it low through the reset cycle.
  assign req_ready_o = !rst_i && (state_q != StWait);
  assign accept      = req_valid_i && req_ready_o;

  // Read data is captured from the pre-write array view at the acceptance edge.
  assign fresh_rdata = (req_we_i || !req_ok) ? '0 : arr_rdata;

  dmem_array #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AddrW (AddrW)
  ) u_array (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (accept && req_we_i && req_ok),
    .be_i    (req_be_i),
    .addr_i  (word_idx),
    .wdata_i (req_wdata_i),
    .rdata_o (arr_rdata)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    pend_rdata_d = pend_rdata_q;
    pend_err_d   = pend_err_q;
    rsp_valid_d  = 1'b0;
    rsp_rdata_d  = '0;
    rsp_err_d    = 1'b0;
    unique case (state_q)
      StIdle, StResp: begin
        if (accept) begin
          pend_rdata_d = fresh_rdata;
          pend_err_d   = !req_ok;
          if (LATENCY == 1) begin
            state_d     = StResp;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = fresh_rdata;
            rsp_err_d   = !req_ok;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(LATENCY - 1);
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= CntW'(1)) begin
          state_d     = StResp;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pend_rdata_q;
          rsp_err_d   = pend_err_q;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      pend_rdata_q <= '0;
      pend_err_q   <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      pend_rdata_q <= pend_rdata_d;
      pend_err_q   <= pend_err_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_rdata_o = rsp_rdata_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
